// File: rtl/cmult_share_arbiter_pkg.sv
// Shared constants and helpers for the time-shared complex multiplier.
// Q-format fraction bits and requester-ID width derivation live here.
package cmult_share_arbiter_pkg;

    localparam int WIDTH_DEF = 16;

    function automatic int frac_bits(input int width);
        return width - 1;
    endfunction

    // A single requester still needs a 1-bit ID field.
    function automatic int id_width(input int nreq);
        return (nreq > 1) ? $clog2(nreq) : 1;
    endfunction

endpackage

// File: rtl/cmult_share_arbiter_core.sv
// Combinational Q1.(WIDTH-1) complex product; each partial product is scaled
// and truncated on its own before the wrapping add/subtract.
module cmult_core
    import cmult_share_arbiter_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [WIDTH-1:0] a_re,
    input  logic [WIDTH-1:0] a_im,
    input  logic [WIDTH-1:0] b_re,
    input  logic [WIDTH-1:0] b_im,
    output logic [WIDTH-1:0] p_re,
    output logic [WIDTH-1:0] p_im
);
    localparam int FB = frac_bits(WIDTH);

    logic signed [2*WIDTH-1:0] prod_rr, prod_ii, prod_ri, prod_ir;
    logic [WIDTH-1:0]          t_rr, t_ii, t_ri, t_ir;

    assign prod_rr = $signed(a_re) * $signed(b_re);
    assign prod_ii = $signed(a_im) * $signed(b_im);
    assign prod_ri = $signed(a_re) * $signed(b_im);
    assign prod_ir = $signed(a_im) * $signed(b_re);

    assign t_rr = WIDTH'(prod_rr >>> FB);
    assign t_ii = WIDTH'(prod_ii >>> FB);
    assign t_ri = WIDTH'(prod_ri >>> FB);
    assign t_ir = WIDTH'(prod_ir >>> FB);

    assign p_re = t_rr - t_ii;
    assign p_im = t_ri + t_ir;

endmodule

// File: rtl/cmult_share_arbiter.sv
// Round-robin arbiter feeding one shared complex multiplier through a
// two-stage pipeline (operand register, result register) with backpressure.
module cmult_share_arbiter
    import cmult_share_arbiter_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int NREQ  = 2,
    parameter int IDW   = id_width(NREQ)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a_re,
    input  logic [NREQ*WIDTH-1:0] req_a_im,
    input  logic [NREQ*WIDTH-1:0] req_b_re,
    input  logic [NREQ*WIDTH-1:0] req_b_im,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic [WIDTH-1:0]      rsp_re,
    output logic [WIDTH-1:0]      rsp_im
);
    logic [WIDTH-1:0] a_re_arr [NREQ];
    logic [WIDTH-1:0] a_im_arr [NREQ];
    logic [WIDTH-1:0] b_re_arr [NREQ];
    logic [WIDTH-1:0] b_im_arr [NREQ];

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
        assign a_re_arr[gi] = req_a_re[gi*WIDTH +: WIDTH];
        assign a_im_arr[gi] = req_a_im[gi*WIDTH +: WIDTH];
        assign b_re_arr[gi] = req_b_re[gi*WIDTH +: WIDTH];
        assign b_im_arr[gi] = req_b_im[gi*WIDTH +: WIDTH];
    end

    logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
    logic             s1_valid_q, s1_valid_d;
    logic [IDW-1:0]   s1_id_q, s1_id_d;
    logic [WIDTH-1:0] s1_a_re_q, s1_a_re_d, s1_a_im_q, s1_a_im_d;
    logic [WIDTH-1:0] s1_b_re_q, s1_b_re_d, s1_b_im_q, s1_b_im_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0]   rsp_id_q, rsp_id_d;
    logic [WIDTH-1:0] rsp_re_q, rsp_re_d, rsp_im_q, rsp_im_d;

    logic             advance, grant_any, accept;
    logic [IDW-1:0]   grant_idx, cand_idx;
    logic [WIDTH-1:0] core_re, core_im;

    // Search from rr_ptr upward, wrapping at NREQ; first valid wins.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        cand_idx  = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand_idx = IDW'((int'(rr_ptr_q) + k) % NREQ);
            if (!grant_any && req_valid[cand_idx]) begin
                grant_any = 1'b1;
                grant_idx = cand_idx;
            end
        end
    end

    assign advance   = !rsp_valid_q || rsp_ready;
    assign accept    = advance && grant_any && !reset;
    assign req_ready = accept ? (NREQ'(1) << grant_idx) : '0;

    cmult_core #(.WIDTH(WIDTH)) u_core (
        .a_re (s1_a_re_q),
        .a_im (s1_a_im_q),
        .b_re (s1_b_re_q),
        .b_im (s1_b_im_q),
        .p_re (core_re),
        .p_im (core_im)
    );

    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        s1_valid_d  = s1_valid_q;
        s1_id_d     = s1_id_q;
        s1_a_re_d   = s1_a_re_q;
        s1_a_im_d   = s1_a_im_q;
        s1_b_re_d   = s1_b_re_q;
        s1_b_im_d   = s1_b_im_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_re_d    = rsp_re_q;
        rsp_im_d    = rsp_im_q;
        if (advance) begin
            s1_valid_d  = accept;
            rsp_valid_d = s1_valid_q;
            rsp_id_d    = s1_id_q;
            rsp_re_d    = core_re;
            rsp_im_d    = core_im;
            if (accept) begin
                s1_id_d   = grant_idx;
                s1_a_re_d = a_re_arr[grant_idx];
                s1_a_im_d = a_im_arr[grant_idx];
                s1_b_re_d = b_re_arr[grant_idx];
                s1_b_im_d = b_im_arr[grant_idx];
                rr_ptr_d  = IDW'((int'(grant_idx) + 1) % NREQ);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rr_ptr_q    <= '0;
            s1_valid_q  <= 1'b0;
            s1_id_q     <= '0;
            s1_a_re_q   <= '0;
            s1_a_im_q   <= '0;
            s1_b_re_q   <= '0;
            s1_b_im_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_re_q    <= '0;
            rsp_im_q    <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            s1_valid_q  <= s1_valid_d;
            s1_id_q     <= s1_id_d;
            s1_a_re_q   <= s1_a_re_d;
            s1_a_im_q   <= s1_a_im_d;
            s1_b_re_q   <= s1_b_re_d;
            s1_b_im_q   <= s1_b_im_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_re_q    <= rsp_re_d;
            rsp_im_q    <= rsp_im_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_re    = rsp_re_q;
    assign rsp_im    = rsp_im_q;

endmodule

// File: tb/tb_cmult_share_arbiter.sv
// Self-checking bench: directed scenarios plus a randomized run, all results
// checked against a queue-based reference model of arbitration and arithmetic.
module tb_cmult_share_arbiter;
    localparam int W = 16;
    localparam int N = 2;

    logic           clock;
    logic           reset;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_a_re, req_a_im, req_b_re, req_b_im;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [0:0]     rsp_id;
    logic [W-1:0]   rsp_re, rsp_im;

    cmult_share_arbiter #(.WIDTH(W), .NREQ(N), .IDW(1)) dut (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a_re  (req_a_re),
        .req_a_im  (req_a_im),
        .req_b_re  (req_b_re),
        .req_b_im  (req_b_im),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_re    (rsp_re),
        .rsp_im    (rsp_im)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        int           id;
        logic [W-1:0] re;
        logic [W-1:0] im;
    } exp_t;

    exp_t sb[$];
    int   model_ptr = 0;

    // One Q15 partial product: full-precision multiply, floor-scale, keep low W bits.
    function automatic logic [W-1:0] qmul(input logic signed [W-1:0] x, input logic signed [W-1:0] y);
        longint p;
        p = longint'(x) * longint'(y);
        p = p >>> (W - 1);
        return p[W-1:0];
    endfunction

    // Reference model: predicts grants, builds the expected result stream, checks responses.
    always @(negedge clock) begin
        logic [N-1:0] exp_g;
        logic [W-1:0] ar, ai, br, bi;
        exp_t         e;
        exp_t         got;
        bit           found;
        int           idx;
        exp_g = '0;
        if (reset) begin
            sb.delete();
            model_ptr = 0;
            vectors++;
            if (req_ready !== '0) begin
                miscompares++;
                $display("FAIL reset_ready: got %b want 00", req_ready);
            end
        end else begin
            found = 0;
            if (!rsp_valid || rsp_ready) begin
                for (int k = 0; k < N; k++) begin
                    idx = (model_ptr + k) % N;
                    if (!found && req_valid[idx]) begin
                        found = 1;
                        exp_g[idx] = 1'b1;
                    end
                end
            end
            vectors++;
            if (req_ready !== exp_g) begin
                miscompares++;
                $display("FAIL grant: got %b want %b (valid %b ptr %0d)", req_ready, exp_g, req_valid, model_ptr);
            end
            if (rsp_valid === 1'b1 && rsp_ready) begin
                vectors++;
                if (sb.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_rsp: got id %0d re %0d im %0d, want none", rsp_id, $signed(rsp_re), $signed(rsp_im));
                end else begin
                    e = sb.pop_front();
                    got.id = int'(rsp_id);
                    got.re = rsp_re;
                    got.im = rsp_im;
                    if (got.id !== e.id || got.re !== e.re || got.im !== e.im) begin
                        miscompares++;
                        $display("FAIL rsp: got id %0d re %0d im %0d, want id %0d re %0d im %0d",
                                 got.id, $signed(got.re), $signed(got.im), e.id, $signed(e.re), $signed(e.im));
                    end
                end
            end
            for (int i = 0; i < N; i++) begin
                if (exp_g[i]) begin
                    ar = req_a_re[i*W +: W];
                    ai = req_a_im[i*W +: W];
                    br = req_b_re[i*W +: W];
                    bi = req_b_im[i*W +: W];
                    e.id = i;
                    e.re = qmul(ar, br) - qmul(ai, bi);
                    e.im = qmul(ar, bi) + qmul(ai, br);
                    sb.push_back(e);
                    model_ptr = (i + 1) % N;
                end
            end
        end
    end

    task automatic set_ops(input int i, input int ar, input int ai, input int br, input int bi);
        req_a_re[i*W +: W] = W'(ar);
        req_a_im[i*W +: W] = W'(ai);
        req_b_re[i*W +: W] = W'(br);
        req_b_im[i*W +: W] = W'(bi);
    endtask

    task automatic pulse_reset(input int cycles);
        @(posedge clock); #1;
        reset = 1'b1;
        repeat (cycles) @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset;
        req_valid = 2'b11;
        rsp_ready = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        vectors++;
        if (rsp_valid !== 1'b0 || rsp_id !== 1'b0 || rsp_re !== '0 || rsp_im !== '0) begin
            miscompares++;
            $display("FAIL reset_state: got v%b id%0d re%0d im%0d want all 0", rsp_valid, rsp_id, rsp_re, rsp_im);
        end
        #1;
        req_valid = '0;
        @(posedge clock); #1;
        reset = 1'b0;
    endtask

    task automatic single_op(input string name, input int ar, input int ai, input int br, input int bi,
                             input int want_re, input int want_im);
        @(posedge clock); #1;
        set_ops(0, ar, ai, br, bi);
        req_valid = 2'b01;
        rsp_ready = 1'b1;
        @(negedge clock);
        vectors++;
        if (req_ready !== 2'b01) begin
            miscompares++;
            $display("FAIL %s_ready: got %b want 01", name, req_ready);
        end
        @(posedge clock); #1;
        req_valid = '0;
        @(negedge clock);
        vectors++;
        if (rsp_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL %s_early: rsp_valid got %b want 0", name, rsp_valid);
        end
        @(negedge clock);
        vectors++;
        if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_re !== W'(want_re) || rsp_im !== W'(want_im)) begin
            miscompares++;
            $display("FAIL %s_result: got v%b id%0d re%0d im%0d want v1 id0 re%0d im%0d",
                     name, rsp_valid, rsp_id, $signed(rsp_re), $signed(rsp_im), want_re, want_im);
        end
    endtask

    task automatic test_single;
        single_op("single", 16384, 16384, 16384, -16384, 16384, 0);
    endtask

    task automatic test_wrap;
        single_op("wrap", -32768, 0, -32768, 0, -32768, 0);
    endtask

    task automatic test_back_to_back;
        int n;
        bit started;
        n = 0;
        started = 0;
        pulse_reset(1);
        set_ops(0, 8192, 0, 32767, 0);
        set_ops(1, 0, 8192, 32767, 0);
        req_valid = 2'b11;
        rsp_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clock);
            if (rsp_valid === 1'b1) begin
                started = 1;
                vectors++;
                if (int'(rsp_id) != n % 2 || rsp_re !== ((n % 2) ? W'(0) : W'(8191)) ||
                    rsp_im !== ((n % 2) ? W'(8191) : W'(0))) begin
                    miscompares++;
                    $display("FAIL rotate[%0d]: got id%0d re%0d im%0d want id%0d", n, rsp_id,
                             $signed(rsp_re), $signed(rsp_im), n % 2);
                end
                n++;
            end else if (started) begin
                vectors++;
                miscompares++;
                $display("FAIL rotate_gap: got rsp_valid 0 want 1 at result %0d", n);
            end
        end
        vectors++;
        if (n < 6) begin
            miscompares++;
            $display("FAIL rotate_count: got %0d results want >= 6", n);
        end
        @(posedge clock); #1;
        req_valid = '0;
    endtask

    task automatic test_backpressure;
        logic [W-1:0] hold_re, hold_im;
        logic [0:0]   hold_id;
        for (int i = 0; i < N; i++)
            set_ops(i, int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)),
                    int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)));
        req_valid = 2'b11;
        rsp_ready = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        rsp_ready = 1'b0;
        @(negedge clock);
        hold_re = rsp_re;
        hold_im = rsp_im;
        hold_id = rsp_id;
        for (int c = 0; c < 5; c++) begin
            vectors++;
            if (rsp_valid !== 1'b1 || rsp_re !== hold_re || rsp_im !== hold_im ||
                rsp_id !== hold_id || req_ready !== '0) begin
                miscompares++;
                $display("FAIL stall[%0d]: got v%b id%0d re%0d im%0d ready %b want held, ready 00",
                         c, rsp_valid, rsp_id, $signed(rsp_re), $signed(rsp_im), req_ready);
            end
            @(negedge clock);
        end
        @(posedge clock); #1;
        rsp_ready = 1'b1;
        repeat (4) @(posedge clock);
        #1;
        req_valid = '0;
    endtask

    task automatic test_fairness;
        int accepts;
        accepts = 0;
        pulse_reset(1);
        req_valid = 2'b10;
        rsp_ready = 1'b1;
        for (int c = 0; c < 20 && accepts < 3; c++) begin
            @(negedge clock);
            if (req_ready[1] && req_valid[1]) accepts++;
        end
        vectors++;
        if (accepts != 3) begin
            miscompares++;
            $display("FAIL fair_accepts: got %0d want 3", accepts);
        end
        @(posedge clock); #1;
        req_valid = 2'b11;
        @(negedge clock);
        vectors++;
        if (req_ready !== 2'b01) begin
            miscompares++;
            $display("FAIL fair_next: got %b want 01", req_ready);
        end
        @(posedge clock); #1;
        req_valid = '0;
    endtask

    task automatic test_reset_mid;
        req_valid = 2'b11;
        rsp_ready = 1'b1;
        repeat (4) @(posedge clock);
        #1;
        reset = 1'b1;
        @(negedge clock);
        vectors++;
        if (rsp_valid !== 1'b1 || req_ready !== '0) begin
            miscompares++;
            $display("FAIL midreset_pre: got v%b ready %b want v1 ready 00", rsp_valid, req_ready);
        end
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        vectors++;
        if (rsp_valid !== 1'b0 || req_ready !== 2'b01) begin
            miscompares++;
            $display("FAIL midreset_post: got v%b ready %b want v0 ready 01", rsp_valid, req_ready);
        end
        repeat (3) @(posedge clock);
        #1;
        req_valid = '0;
    endtask

    task automatic test_random(input int cycles);
        logic [N-1:0] hs;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clock);
            hs = req_valid & req_ready;
            @(posedge clock); #1;
            for (int i = 0; i < N; i++) begin
                if (hs[i] || !req_valid[i]) begin
                    req_valid[i] = ($urandom_range(0, 3) != 0);
                    set_ops(i, int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)),
                            int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)));
                end
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (5) @(posedge clock);
        @(negedge clock);
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d outstanding want 0", sb.size());
        end
    endtask

    initial begin
        reset     = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b0;
        req_a_re  = '0;
        req_a_im  = '0;
        req_b_re  = '0;
        req_b_im  = '0;
        test_reset;
        test_single;
        test_wrap;
        test_back_to_back;
        test_backpressure;
        test_fairness;
        test_reset_mid;
        test_random(400);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
